// File: rtl/systolic_tile_sequencer_if.sv
// Bundle between the tile sequencer, its host/operand buffers and the grid edge.
// master = host side (starts tiles, returns buffer data); slave = sequencer.
interface systolic_tile_sequencer_if #(
    parameter int ARRAY_N  = 4,
    parameter int INPUTS_N = 8,
    parameter int KLEN_N   = 7
);
    logic                          Start;
    logic [KLEN_N-1:0]             K_Len;
    logic                          Busy;
    logic                          Done;
    logic                          Act_Rd_En;
    logic [KLEN_N-1:0]             Act_Rd_Addr;
    logic [ARRAY_N*INPUTS_N-1:0]   Act_Rd_Data;
    logic                          Wt_Rd_En;
    logic [KLEN_N-1:0]             Wt_Rd_Addr;
    logic [ARRAY_N*INPUTS_N-1:0]   Wt_Rd_Data;
    logic                          Array_Clear;
    logic [ARRAY_N-1:0]            Array_Act_Valid;
    logic [ARRAY_N*INPUTS_N-1:0]   Array_Act;
    logic [ARRAY_N-1:0]            Array_Weight_Valid;
    logic [ARRAY_N*INPUTS_N-1:0]   Array_Weight;

    modport master (
        output Start, K_Len, Act_Rd_Data, Wt_Rd_Data,
        input  Busy, Done, Act_Rd_En, Act_Rd_Addr, Wt_Rd_En, Wt_Rd_Addr,
               Array_Clear, Array_Act_Valid, Array_Act, Array_Weight_Valid, Array_Weight
    );

    modport slave (
        input  Start, K_Len, Act_Rd_Data, Wt_Rd_Data,
        output Busy, Done, Act_Rd_En, Act_Rd_Addr, Wt_Rd_En, Wt_Rd_Addr,
               Array_Clear, Array_Act_Valid, Array_Act, Array_Weight_Valid, Array_Weight
    );
endinterface

// File: rtl/systolic_tile_sequencer.sv
// Output-stationary tile sequencer: clears the grid, streams K operand
// columns/rows from the buffers, skews them into diagonal wavefronts on the
// grid edges, waits out the pipeline drain and pulses Done.

// One skew lane: DEPTH registers with the valid travelling beside the data.
// Data is zeroed at entry whenever the valid is low, so it stays zero downstream.
module systolic_skew_lane #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data
);
    logic [DEPTH-1:0]        vld_pipe;
    logic [DEPTH-1:0][W-1:0] data_pipe;

    // Shift valid and masked data down the lane
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe[0]  <= in_vld;
            data_pipe[0] <= in_vld ? in_data : '0;
            for (int s = 1; s < DEPTH; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                data_pipe[s] <= data_pipe[s-1];
            end
        end
    end

    assign out_vld  = vld_pipe[DEPTH-1];
    assign out_data = data_pipe[DEPTH-1];
endmodule

module systolic_tile_sequencer #(
    parameter int ARRAY_N  = 4,
    parameter int INPUTS_N = 8,
    parameter int KLEN_N   = 7
) (
    input  logic                    Clock,
    input  logic                    Reset,
    systolic_tile_sequencer_if.slave bus
);
    // Drain covers the skew (2N) plus the node's extra accumulate stage
    localparam int DRAIN_CYC = 2*ARRAY_N + 1;
    localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [KLEN_N-1:0]   k_len_q, k_len_d;
    logic [KLEN_N-1:0]   addr_q, addr_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                busy, done, rd_en, clear;
    logic                rd_vld_q;

    logic [ARRAY_N-1:0]               act_vld, wt_vld;
    logic [ARRAY_N-1:0][INPUTS_N-1:0] act_dat, wt_dat;

    // State, latched K, stream address and drain counter
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            k_len_q <= '0;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = CLEAR;
                    k_len_d = bus.K_Len;
                end
            end
            CLEAR: begin
                busy    = 1'b1;
                clear   = 1'b1;
                state_d = (k_len_q != '0) ? STREAM : DONE;
            end
            STREAM: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (addr_q == k_len_q - KLEN_N'(1)) begin
                    addr_d  = '0;
                    drain_d = DRAIN_W'(DRAIN_CYC - 1);
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + KLEN_N'(1);
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_q == '0) state_d = DONE;
                else               drain_d = drain_q - DRAIN_W'(1);
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer data returns one cycle after the strobe; both buffers share it
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) rd_vld_q <= 1'b0;
        else       rd_vld_q <= rd_en;
    end

    // Lane i gets i+1 stages, forming the diagonal wavefront on each edge
    for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
        systolic_skew_lane #(.DEPTH(i+1), .W(INPUTS_N)) u_act (
            .Clock    (Clock),
            .Reset    (Reset),
            .in_vld   (rd_vld_q),
            .in_data  (bus.Act_Rd_Data[i*INPUTS_N +: INPUTS_N]),
            .out_vld  (act_vld[i]),
            .out_data (act_dat[i])
        );
        systolic_skew_lane #(.DEPTH(i+1), .W(INPUTS_N)) u_wt (
            .Clock    (Clock),
            .Reset    (Reset),
            .in_vld   (rd_vld_q),
            .in_data  (bus.Wt_Rd_Data[i*INPUTS_N +: INPUTS_N]),
            .out_vld  (wt_vld[i]),
            .out_data (wt_dat[i])
        );
    end

    assign bus.Busy               = busy;
    assign bus.Done               = done;
    assign bus.Act_Rd_En          = rd_en;
    assign bus.Wt_Rd_En           = rd_en;
    assign bus.Act_Rd_Addr        = addr_q;
    assign bus.Wt_Rd_Addr         = addr_q;
    assign bus.Array_Clear        = clear;
    assign bus.Array_Act_Valid    = act_vld;
    assign bus.Array_Act          = act_dat;
    assign bus.Array_Weight_Valid = wt_vld;
    assign bus.Array_Weight       = wt_dat;
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: operand buffer model, cycle-exact edge
// expectations derived from the tile timing, and a behavioural grid that
// accumulates the skewed edge streams and is compared against A*B.
module tb_systolic_tile_sequencer;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int KW = 7;
    localparam int HN = 64;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic signed [W-1:0] a_mem [N][128];
    logic signed [W-1:0] b_mem [128][N];

    logic [N-1:0]        h_av [HN];
    logic [N-1:0]        h_wv [HN];
    logic signed [W-1:0] h_a  [HN][N];
    logic signed [W-1:0] h_w  [HN][N];

    systolic_tile_sequencer_if #(.ARRAY_N(N), .INPUTS_N(W), .KLEN_N(KW)) bus ();

    systolic_tile_sequencer #(.ARRAY_N(N), .INPUTS_N(W), .KLEN_N(KW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Operand buffers: one-cycle read latency, junk when not read
    always @(posedge Clock) begin
        for (int i = 0; i < N; i++) begin
            bus.Act_Rd_Data[i*W +: W] <= bus.Act_Rd_En ? a_mem[i][bus.Act_Rd_Addr] : W'($urandom);
            bus.Wt_Rd_Data[i*W +: W]  <= bus.Wt_Rd_En  ? b_mem[bus.Wt_Rd_Addr][i]  : W'($urandom);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ctrl"}, {bus.Busy, bus.Done, bus.Act_Rd_En, bus.Wt_Rd_En, bus.Array_Clear,
                               bus.Act_Rd_Addr, bus.Wt_Rd_Addr}, 64'd0);
        check({tag, "_vld"},  {bus.Array_Act_Valid, bus.Array_Weight_Valid}, 64'd0);
        check({tag, "_act"},  bus.Array_Act, 64'd0);
        check({tag, "_wt"},   bus.Array_Weight, 64'd0);
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int k = 0; k < 128; k++)
            for (int i = 0; i < N; i++) begin
                a_mem[i][k] = W'(av);
                b_mem[k][i] = W'(bv);
            end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 128; k++)
            for (int i = 0; i < N; i++) begin
                a_mem[i][k] = W'($urandom);
                b_mem[k][i] = W'($urandom);
            end
    endtask

    // Runs one tile from IDLE (called at a negedge). Cycle c counts from the
    // edge that samples Start (c=1 is CLEAR, c=2 first STREAM cycle).
    task automatic run_tile(input string name, input int k, input bit poke_stream, input bit poke_done);
        int          done_c;
        int          kk;
        bit          ev, er;
        logic [W-1:0] ea, ew;
        int          acc, expc;
        done_c = (k == 0) ? 2 : k + 2*N + 3;
        for (int c = 0; c < HN; c++) begin
            h_av[c] = '0;
            h_wv[c] = '0;
        end
        bus.K_Len = KW'(k);
        bus.Start = 1'b1;
        @(posedge Clock);
        for (int c = 1; c <= done_c + 2; c++) begin
            @(negedge Clock);
            bus.Start = 1'b0;
            bus.K_Len = KW'($urandom);
            if (poke_stream && c == 3) bus.Start = 1'b1;
            if (poke_done && c == done_c) bus.Start = 1'b1;
            er = (k > 0) && (c >= 2) && (c < k + 2);
            check($sformatf("%s_busy_c%0d", name, c), bus.Busy, (c <= done_c) ? 64'd1 : 64'd0);
            check($sformatf("%s_done_c%0d", name, c), bus.Done, (c == done_c) ? 64'd1 : 64'd0);
            check($sformatf("%s_clr_c%0d", name, c), bus.Array_Clear, (c == 1) ? 64'd1 : 64'd0);
            check($sformatf("%s_rden_c%0d", name, c), {bus.Act_Rd_En, bus.Wt_Rd_En}, er ? 64'd3 : 64'd0);
            check($sformatf("%s_addr_c%0d", name, c), {bus.Act_Rd_Addr, bus.Wt_Rd_Addr},
                  er ? {50'd0, 7'(c-2), 7'(c-2)} : 64'd0);
            for (int i = 0; i < N; i++) begin
                kk = c - 4 - i;
                ev = (kk >= 0) && (kk < k);
                ea = ev ? a_mem[i][kk] : '0;
                ew = ev ? b_mem[kk][i] : '0;
                check($sformatf("%s_av%0d_c%0d", name, i, c), bus.Array_Act_Valid[i], {63'd0, ev});
                check($sformatf("%s_wv%0d_c%0d", name, i, c), bus.Array_Weight_Valid[i], {63'd0, ev});
                check($sformatf("%s_a%0d_c%0d", name, i, c), bus.Array_Act[i*W +: W], ea);
                check($sformatf("%s_w%0d_c%0d", name, i, c), bus.Array_Weight[i*W +: W], ew);
                h_av[c][i] = bus.Array_Act_Valid[i];
                h_wv[c][i] = bus.Array_Weight_Valid[i];
                h_a[c][i]  = bus.Array_Act[i*W +: W];
                h_w[c][i]  = bus.Array_Weight[i*W +: W];
            end
        end
        bus.Start = 1'b0;
        // Grid: node (i,j) meets row i's stream j cycles late and column j's i cycles late
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc  = 0;
                expc = 0;
                for (int c = 1; c <= done_c + 2; c++)
                    if (c - j >= 1 && c - i >= 1 && h_av[c-j][i] && h_wv[c-i][j])
                        acc += h_a[c-j][i] * h_w[c-i][j];
                for (int q = 0; q < k; q++) expc += a_mem[i][q] * b_mem[q][j];
                check($sformatf("%s_acc_%0d_%0d", name, i, j), 64'(acc), 64'(expc));
            end
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.K_Len = '0;
        fill_const(0, 0);
        repeat (2) @(negedge Clock);
        check_idle_zero("rst_held");
        Reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            check_idle_zero($sformatf("rst_idle%0d", c));
        end

        fill_const(2, -3);
        run_tile("k1", 1, 1'b0, 1'b0);

        fill_rand();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < N; i++) begin
                a_mem[i][k] = (i == k) ? W'(1) : W'(0);
                b_mem[k][i] = W'(4*k + i + 1);
            end
        run_tile("k4id", 4, 1'b0, 1'b0);

        fill_rand();
        run_tile("k0", 0, 1'b0, 1'b0);

        fill_rand();
        run_tile("poke", 5, 1'b1, 1'b1);
        fill_const(1, 1);
        run_tile("k2ones", 2, 1'b0, 1'b0);

        // Reset in cycle S+2 of a K=8 run
        fill_rand();
        bus.K_Len = KW'(8);
        bus.Start = 1'b1;
        @(posedge Clock);
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clock);
            bus.Start = 1'b0;
        end
        check("mid_busy", {bus.Busy, bus.Act_Rd_En}, 64'd3);
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        check_idle_zero("mid_rst");
        Reset = 1'b0;
        @(negedge Clock);
        check_idle_zero("mid_rel");
        fill_const(5, 7);
        run_tile("k1after", 1, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            fill_rand();
            run_tile($sformatf("rnd%0d", r), int'($urandom_range(1, 12)), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/systolic_tile_sequencer.md
# systolic_tile_sequencer

Controller that runs one output-stationary matrix-multiply tile on an ARRAY_N x ARRAY_N grid of SystolicNode cells. It clears the grid's accumulators and fetches one A column and one B row per cycle from two operand buffers. It skews the fetched vectors into diagonal wavefronts on the grid's row (activation) and column (weight) edges, then counts out the pipeline drain. When every node's Accum_Out is final, it pulses Done. It sits between the operand buffers and the grid edge.

## Interface
- ARRAY_N, 4, grid dimension (rows = columns)
- INPUTS_N, 8, signed operand width, matches the grid's node operand width
- KLEN_N, 7, width of reduction-length field and buffer addresses
- Clock  in  1  sole clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state and outputs
- Start  in  1  one-cycle request; honoured only in IDLE
- K_Len  in  KLEN_N  reduction depth K, sampled with accepted Start
- Busy  out  1  high from the cycle after an accepted Start through the Done cycle inclusive
- Done  out  1  one-cycle pulse; grid accumulators are final and held
- Act_Rd_En  out  1  A-buffer read strobe
- Act_Rd_Addr  out  KLEN_N  A column index k
- Act_Rd_Data  in  ARRAY_N*INPUTS_N  A[i][k] in slice i; valid the cycle after Act_Rd_En
- Wt_Rd_En  out  1  B-buffer read strobe
- Wt_Rd_Addr  out  KLEN_N  B row index k
- Wt_Rd_Data  in  ARRAY_N*INPUTS_N  B[k][j] in slice j; valid the cycle after Wt_Rd_En
- Array_Clear  out  1  drives every node's Clear
- Array_Act_Valid  out  ARRAY_N  bit i drives Act_Valid_In of row i, column-0 node
- Array_Act  out  ARRAY_N*INPUTS_N  slice i drives Act_In of row i
- Array_Weight_Valid  out  ARRAY_N  bit j drives Weight_Valid_In of column j, row-0 node
- Array_Weight  out  ARRAY_N*INPUTS_N  slice j drives Weight_In of column j

## Operation
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE. The reset state is IDLE.
- IDLE -> CLEAR on Start. K_Len is latched on the same edge.
- CLEAR lasts 1 cycle with Array_Clear=1. It goes to STREAM if K>0, otherwise directly to DONE.
- STREAM lasts K cycles. Act_Rd_En and Wt_Rd_En are both 1. Both addresses equal a counter running 0..K-1, which wraps to 0 on exit.
- DRAIN lasts 2*ARRAY_N+1 cycles, timed by a down-counter. DONE lasts 1 cycle (Done=1), then the FSM returns to IDLE.
- Skew: lane i (act and weight alike) passes returned data through i+1 registers. Valid bits travel alongside the data.
- Lane data output is forced to 0 whenever that lane's valid is 0. Operands pass through unmodified as signed INPUTS_N values; there is no arithmetic in this block.
- Start is ignored in every state except IDLE, including the DONE cycle. K_Len changes are ignored after latching.
- Reset at any time, including mid-STREAM: on the next edge the block is in IDLE and all skew registers, valids, data, counters and strobes are 0. The grid shares Reset and is cleared with it.
- The grid's accumulators are not cleared at Done. Results are held until the next run's CLEAR.

## Timing
- Let t0 be the edge that samples Start. CLEAR is cycle t0+1 and S = t0+2 is the first STREAM cycle.
- Read address k is presented in cycle S+k.
- Lane i element k appears on Array_Act / Array_Weight with its valid in cycle S+2+k+i. Each lane's valid is high for exactly K consecutive cycles.
- Node (i,j) sees its element-k operands in cycle S+2+k+i+j. This follows from the grid's 1-cycle pass-through.
- The node accumulator updates 2 edges after its operands are presented. The last update is at node (N-1,N-1) and is visible in cycle S+K+2N+1.
- Done is asserted in cycle t0+K+2*ARRAY_N+3. For K=0, Done is asserted in cycle t0+2.
- Reset values: Busy, Done, both Rd_En, both addresses, Array_Clear, all valids and all data are 0.
- The earliest new Start is the cycle after Done (IDLE). Back-to-back tiles therefore have a 1-cycle gap plus CLEAR.

## Test plan
- Reset asserted, then deasserted -> every output is 0 and Busy=0. This holds through 5 idle cycles.
- ARRAY_N=4, K=1, A column all 2, B row all -3, sequencer driving a SystolicNode grid -> Array_Clear at t0+1, lane i valid only in cycle t0+4+i, Done at t0+12, all 16 Accum_Out = -6.
- K=4, A = identity, B[k][j] = 4k+j+1 -> each lane's valid is high for 4 cycles, Done at t0+15, Accum_Out(i,j) = 4i+j+1.
- K=0 -> Array_Clear at t0+1, Done at t0+2, Rd_En never asserted, all valids stay 0.
- Start pulsed during STREAM and during DONE -> ignored, with no timing change. A second tile with K=2 and all operands 1, started after the first tile, gives Accum_Out = 2 everywhere, so the first tile's results are cleared.
- Reset asserted in cycle S+2 of a K=8 run -> all outputs are 0 on the next edge. A following K=1 run (A=5, B=7) gives 35 everywhere, with Done at t0+12.
